// File: rtl/rename_regfile_mp_pkg.sv
// Shared widths, types and sizing for the multi-port rename register file
// and its checkpoint store.
package rename_regfile_mp_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_NUM    = 32;
  localparam int REG_IDX_W  = $clog2(REG_NUM);
  localparam int ROB_IDX_W  = 4;
  localparam int ISSUE_W    = 2;
  localparam int COMMIT_W   = 2;
  localparam int CKPT_NUM   = 4;
  localparam int CKPT_IDX_W = $clog2(CKPT_NUM);
  localparam int RD_PORTS   = 2 * ISSUE_W;

  typedef logic [DATA_W-1:0]      data_t;
  typedef logic [REG_IDX_W-1:0]   reg_idx_t;
  typedef logic [ROB_IDX_W-1:0]   rob_idx_t;
  typedef logic [CKPT_IDX_W-1:0]  ckpt_idx_t;
  typedef logic [CKPT_IDX_W:0]    ckpt_cnt_t;
  typedef logic [REG_NUM-1:0]     busy_vec_t;
  typedef rob_idx_t [REG_NUM-1:0] tag_vec_t;

  localparam ckpt_cnt_t CKPT_CNT_FULL = ckpt_cnt_t'(CKPT_NUM);
  localparam ckpt_cnt_t CKPT_CNT_ONE  = ckpt_cnt_t'(1);
  localparam ckpt_idx_t CKPT_IDX_ONE  = ckpt_idx_t'(1);

  // A retiring slot releases an entry only if it carries that entry's producer tag.
  function automatic logic commit_clears(input logic valid, input reg_idx_t c_rd,
                                         input rob_idx_t c_rob, input reg_idx_t e_rd,
                                         input rob_idx_t e_tag);
    return valid && (c_rd != '0) && (c_rd == e_rd) && (c_rob == e_tag);
  endfunction
endpackage

// File: rtl/rename_regfile_mp_ckpt_store.sv
// Ring of rename-table snapshots (busy/tag only) with head/tail/count
// bookkeeping; retirements also clear matching busy bits inside snapshots.
module rename_ckpt_store
  import rename_regfile_mp_pkg::*;
(
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clr_in,
  input  logic                          take,
  input  logic                          restore,
  input  ckpt_idx_t                     restore_id,
  input  logic                          rel,
  input  logic [COMMIT_W-1:0]           commit_valid,
  input  logic [COMMIT_W*REG_IDX_W-1:0] commit_rd,
  input  logic [COMMIT_W*ROB_IDX_W-1:0] commit_rob,
  input  busy_vec_t                     snap_busy,
  input  tag_vec_t                      snap_tag,
  output busy_vec_t                     restore_busy,
  output tag_vec_t                      restore_tag,
  output ckpt_idx_t                     ckpt_id,
  output logic                          ckpt_full
);
  busy_vec_t snap_busy_r     [CKPT_NUM];
  tag_vec_t  snap_tag_r      [CKPT_NUM];
  busy_vec_t snap_busy_nxt_s [CKPT_NUM];
  ckpt_idx_t head_r, tail_r, head_nxt_s, tail_nxt_s;
  ckpt_cnt_t count_r, count_nxt_s;
  logic      full_s, take_s, rel_s;

  assign full_s       = (count_r == CKPT_CNT_FULL);
  assign ckpt_full    = full_s;
  assign ckpt_id      = tail_r;
  assign restore_busy = snap_busy_r[restore_id];
  assign restore_tag  = snap_tag_r[restore_id];

  // Pointer/count update: release first, then restore or take; flush wins.
  always_comb begin
    take_s      = 1'b0;
    rel_s       = 1'b0;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (clr_in) begin
      head_nxt_s  = '0;
      tail_nxt_s  = '0;
      count_nxt_s = '0;
    end else begin
      rel_s      = rel && (count_r != '0);
      head_nxt_s = head_r + ckpt_idx_t'(rel_s);
      if (restore) begin
        tail_nxt_s  = restore_id + CKPT_IDX_ONE;
        count_nxt_s = {1'b0, ckpt_idx_t'(restore_id - head_nxt_s)} + CKPT_CNT_ONE;
      end else begin
        take_s      = take && !full_s;
        tail_nxt_s  = tail_r + ckpt_idx_t'(take_s);
        count_nxt_s = count_r + ckpt_cnt_t'(take_s) - ckpt_cnt_t'(rel_s);
      end
    end
  end

  // Retirements clear matching busy bits in every snapshot.
  always_comb begin
    for (int k = 0; k < CKPT_NUM; k++) begin
      snap_busy_nxt_s[k] = snap_busy_r[k];
      for (int r = 1; r < REG_NUM; r++) begin
        for (int c = 0; c < COMMIT_W; c++) begin
          snap_busy_nxt_s[k][r] = snap_busy_nxt_s[k][r] &
            ~commit_clears(commit_valid[c], commit_rd[c*REG_IDX_W +: REG_IDX_W],
                           commit_rob[c*ROB_IDX_W +: ROB_IDX_W], reg_idx_t'(r),
                           snap_tag_r[k][r]);
        end
      end
    end
  end

  // Snapshot array and pointer registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int k = 0; k < CKPT_NUM; k++) begin
        snap_busy_r[k] <= '0;
        snap_tag_r[k]  <= '0;
      end
    end else if (rdy_in) begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
      for (int k = 0; k < CKPT_NUM; k++) begin
        if (take_s && (tail_r == ckpt_idx_t'(k))) begin
          snap_busy_r[k] <= snap_busy;
          snap_tag_r[k]  <= snap_tag;
        end else begin
          snap_busy_r[k] <= snap_busy_nxt_s[k];
        end
      end
    end
  end
endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-port architectural register file with rename busy/tag table,
// intra-group read bypass and checkpointed mispredict recovery.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
(
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clr_in,
  input  logic [ISSUE_W-1:0]            issue_valid,
  input  logic [ISSUE_W*REG_IDX_W-1:0]  issue_rd,
  input  logic [ISSUE_W*ROB_IDX_W-1:0]  issue_rob,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_idx,
  output logic [RD_PORTS*DATA_W-1:0]    rd_val,
  output logic [RD_PORTS-1:0]           rd_busy,
  output logic [RD_PORTS*ROB_IDX_W-1:0] rd_tag,
  input  logic [COMMIT_W-1:0]           commit_valid,
  input  logic [COMMIT_W*REG_IDX_W-1:0] commit_rd,
  input  logic [COMMIT_W*ROB_IDX_W-1:0] commit_rob,
  input  logic [COMMIT_W*DATA_W-1:0]    commit_val,
  input  logic                          ckpt_take,
  output logic [CKPT_IDX_W-1:0]         ckpt_id,
  output logic                          ckpt_full,
  input  logic                          ckpt_restore,
  input  logic [CKPT_IDX_W-1:0]         ckpt_restore_id,
  input  logic                          ckpt_release
);
  data_t     val_r     [REG_NUM];
  data_t     val_nxt_s [REG_NUM];
  busy_vec_t busy_r, busy_base_s, busy_nxt_s, restore_busy_s;
  tag_vec_t  tag_r, tag_base_s, tag_nxt_s, restore_tag_s;

  rename_ckpt_store u_ckpt (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clr_in       (clr_in),
    .take         (ckpt_take),
    .restore      (ckpt_restore),
    .restore_id   (ckpt_restore_id),
    .rel          (ckpt_release),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_rob   (commit_rob),
    .snap_busy    (busy_nxt_s),
    .snap_tag     (tag_nxt_s),
    .restore_busy (restore_busy_s),
    .restore_tag  (restore_tag_s),
    .ckpt_id      (ckpt_id),
    .ckpt_full    (ckpt_full)
  );

  // Next table: pick base (flush/restore/current), apply commits, then issues.
  always_comb begin
    val_nxt_s = val_r;
    if (clr_in) begin
      busy_base_s = '0;
      tag_base_s  = tag_r;
    end else if (ckpt_restore) begin
      busy_base_s = restore_busy_s;
      tag_base_s  = restore_tag_s;
    end else begin
      busy_base_s = busy_r;
      tag_base_s  = tag_r;
    end
    busy_nxt_s = busy_base_s;
    tag_nxt_s  = tag_base_s;
    for (int c = 0; c < COMMIT_W; c++) begin
      reg_idx_t rd;
      logic     wr;
      rd = commit_rd[c*REG_IDX_W +: REG_IDX_W];
      wr = commit_valid[c] && (rd != '0);
      val_nxt_s[rd]  = wr ? commit_val[c*DATA_W +: DATA_W] : val_nxt_s[rd];
      busy_nxt_s[rd] = (wr && (tag_base_s[rd] == commit_rob[c*ROB_IDX_W +: ROB_IDX_W]))
                       ? 1'b0 : busy_nxt_s[rd];
    end
    // Issues land last so a same-cycle rename overrides a retirement clear.
    for (int s = 0; s < ISSUE_W; s++) begin
      reg_idx_t rd;
      logic     wr;
      rd = issue_rd[s*REG_IDX_W +: REG_IDX_W];
      wr = !clr_in && !ckpt_restore && issue_valid[s] && (rd != '0);
      busy_nxt_s[rd] = wr ? 1'b1 : busy_nxt_s[rd];
      tag_nxt_s[rd]  = wr ? issue_rob[s*ROB_IDX_W +: ROB_IDX_W] : tag_nxt_s[rd];
    end
  end

  // Read ports: stored entry, then commit forward, then older-slot rename, then x0.
  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    rd_tag  = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      reg_idx_t idx;
      data_t    v;
      logic     b;
      rob_idx_t t;
      logic     hit;
      idx = rd_idx[p*REG_IDX_W +: REG_IDX_W];
      v   = val_r[idx];
      b   = busy_r[idx];
      t   = tag_r[idx];
      for (int c = 0; c < COMMIT_W; c++) begin
        hit = busy_r[idx] &&
              commit_clears(commit_valid[c], commit_rd[c*REG_IDX_W +: REG_IDX_W],
                            commit_rob[c*ROB_IDX_W +: ROB_IDX_W], idx, tag_r[idx]);
        v = hit ? commit_val[c*DATA_W +: DATA_W] : v;
        b = hit ? 1'b0 : b;
      end
      for (int j = 0; j < ISSUE_W; j++) begin
        hit = (j < (p / 2)) && issue_valid[j] &&
              (issue_rd[j*REG_IDX_W +: REG_IDX_W] == idx);
        b = hit ? 1'b1 : b;
        t = hit ? issue_rob[j*ROB_IDX_W +: ROB_IDX_W] : t;
      end
      rd_val[p*DATA_W +: DATA_W]       = (idx == '0) ? data_t'(0) : v;
      rd_busy[p]                       = (idx == '0) ? 1'b0 : b;
      rd_tag[p*ROB_IDX_W +: ROB_IDX_W] = (idx == '0) ? rob_idx_t'(0) : t;
    end
  end

  // Value and rename-table registers; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < REG_NUM; r++) begin
        val_r[r] <= '0;
      end
      busy_r <= '0;
      tag_r  <= '0;
    end else if (rdy_in) begin
      val_r  <= val_nxt_s;
      busy_r <= busy_nxt_s;
      tag_r  <= tag_nxt_s;
    end
  end
endmodule
